// File: rtl/rsa_msg_sequencer.sv
// rsa_msg_sequencer
// Host-side sequencer for an RSA modular-exponentiation core. It resets the
// core's key generator, waits for key generation to settle, then accepts one
// message at a time, runs it through the core, and returns the 2*WIDTH result
// (or a timeout indication) on a valid/ready result channel.
//
// Optional feature, enabled by defining RSA_LOOPBACK_CHECK_EN:
//   every successful encryption is immediately decrypted again by the core,
//   and the sticky check_fail flag is raised if the round trip does not
//   reproduce the original plaintext (or if that decryption times out).
//   The host still receives the ciphertext.
// With the macro undefined the loopback states do not exist and check_fail
// is tied low.

module rsa_msg_sequencer #(
   parameter int WIDTH    = 256,
   parameter int KEY_WAIT = 1024,
   parameter int TIMEOUT  = 65535
) (
   input  logic                 clk,
   input  logic                 reset,

   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_data,
   input  logic                 in_encrypt,

   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   out_data,
   output logic                 out_encrypt,
   output logic                 out_error,

   output logic [WIDTH-1:0]     core_msg,
   output logic                 core_encrypt_decrypt,
   output logic                 core_key_rst,
   output logic                 core_exp_rst,

   input  logic                 core_finish,
   input  logic [2*WIDTH-1:0]   core_result,

   output logic                 busy,
   output logic                 check_fail
);

   // A zero wait or timeout makes no sense; clamp so the counters stay legal.
   localparam int KW      = (KEY_WAIT < 1) ? 1 : KEY_WAIT;
   localparam int TW      = (TIMEOUT < 1) ? 1 : TIMEOUT;
   localparam int CNT_MAX = (KW > TW) ? KW : TW;
   localparam int CW      = $clog2(CNT_MAX + 1);

   // Last count value of each timed phase; the phase ends when it is reached.
   localparam logic [CW-1:0] KEY_LAST  = CW'(KW - 1);
   localparam logic [CW-1:0] RUN_LAST  = CW'(TW - 1);
   localparam logic [CW-1:0] LOAD_LAST = CW'(1);

   typedef enum logic [2:0] {
      ST_KEY_INIT,
      ST_KEY_WAIT,
      ST_IDLE,
      ST_LOAD,
      ST_RUN,
      ST_DONE
`ifdef RSA_LOOPBACK_CHECK_EN
      ,
      ST_LB_LOAD,
      ST_LB_RUN
`endif
   } state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        count_q, count_d;
   logic [CW-1:0]        countInc;
   logic [WIDTH-1:0]     coreMsg_q, coreMsg_d;
   logic                 coreEnc_q, coreEnc_d;
   logic                 encrypt_q, encrypt_d;
   logic [2*WIDTH-1:0]   result_q, result_d;
   logic                 error_q, error_d;
   logic                 inRun;

`ifdef RSA_LOOPBACK_CHECK_EN
   logic [WIDTH-1:0]     plain_q, plain_d;
   logic                 checkFail_q, checkFail_d;
`endif

   // Saturating increment shared by every timed phase; it never wraps to 0,
   // which also keeps the "first RUN cycle" test (count == 0) unambiguous.
   assign countInc = (count_q == {CW{1'b1}}) ? count_q : count_q + CW'(1);

   // Next-state and datapath-register update for the request sequencer.
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      coreMsg_d = coreMsg_q;
      coreEnc_d = coreEnc_q;
      encrypt_d = encrypt_q;
      result_d  = result_q;
      error_d   = error_q;
`ifdef RSA_LOOPBACK_CHECK_EN
      plain_d     = plain_q;
      checkFail_d = checkFail_q;
`endif

      case (state_q)
         ST_KEY_INIT: begin
            state_d = ST_KEY_WAIT;
            count_d = '0;
         end

         ST_KEY_WAIT: begin
            if (count_q >= KEY_LAST) begin
               state_d = ST_IDLE;
               count_d = '0;
            end else begin
               count_d = countInc;
            end
         end

         ST_IDLE: begin
            if (in_valid) begin
               coreMsg_d = in_data;
               coreEnc_d = in_encrypt;
               encrypt_d = in_encrypt;
`ifdef RSA_LOOPBACK_CHECK_EN
               plain_d   = in_data;
`endif
               state_d   = ST_LOAD;
               count_d   = '0;
            end
         end

         ST_LOAD: begin
            if (count_q >= LOAD_LAST) begin
               state_d = ST_RUN;
               count_d = '0;
            end else begin
               count_d = countInc;
            end
         end

         ST_RUN: begin
            if ((count_q != '0) && core_finish) begin
               result_d = core_result;
               error_d  = 1'b0;
               count_d  = '0;
`ifdef RSA_LOOPBACK_CHECK_EN
               if (encrypt_q) begin
                  state_d   = ST_LB_LOAD;
                  coreMsg_d = core_result[WIDTH-1:0];
                  coreEnc_d = 1'b0;
               end else begin
                  state_d = ST_DONE;
               end
`else
               state_d = ST_DONE;
`endif
            end else if (count_q >= RUN_LAST) begin
               result_d = '0;
               error_d  = 1'b1;
               state_d  = ST_DONE;
               count_d  = '0;
            end else begin
               count_d = countInc;
            end
         end

         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end

`ifdef RSA_LOOPBACK_CHECK_EN
         ST_LB_LOAD: begin
            if (count_q >= LOAD_LAST) begin
               state_d = ST_LB_RUN;
               count_d = '0;
            end else begin
               count_d = countInc;
            end
         end

         ST_LB_RUN: begin
            if ((count_q != '0) && core_finish) begin
               if (core_result != {{WIDTH{1'b0}}, plain_q}) begin
                  checkFail_d = 1'b1;
               end
               state_d = ST_DONE;
               count_d = '0;
            end else if (count_q >= RUN_LAST) begin
               checkFail_d = 1'b1;
               state_d     = ST_DONE;
               count_d     = '0;
            end else begin
               count_d = countInc;
            end
         end
`endif

         default: begin
            state_d = ST_KEY_INIT;
            count_d = '0;
         end
      endcase
   end

   // State and datapath registers; reset discards any request in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_KEY_INIT;
         count_q   <= '0;
         coreMsg_q <= '0;
         coreEnc_q <= 1'b0;
         encrypt_q <= 1'b0;
         result_q  <= '0;
         error_q   <= 1'b0;
`ifdef RSA_LOOPBACK_CHECK_EN
         plain_q     <= '0;
         checkFail_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         coreMsg_q <= coreMsg_d;
         coreEnc_q <= coreEnc_d;
         encrypt_q <= encrypt_d;
         result_q  <= result_d;
         error_q   <= error_d;
`ifdef RSA_LOOPBACK_CHECK_EN
         plain_q     <= plain_d;
         checkFail_q <= checkFail_d;
`endif
      end
   end

   // The core only runs its exponentiation while one of the run states holds
   // its exponent reset low.
`ifdef RSA_LOOPBACK_CHECK_EN
   assign inRun = (state_q == ST_RUN) || (state_q == ST_LB_RUN);
   assign check_fail = checkFail_q;
`else
   assign inRun = (state_q == ST_RUN);
   assign check_fail = 1'b0;
`endif

   assign in_ready             = (state_q == ST_IDLE);
   assign busy                 = (state_q != ST_IDLE);
   assign out_valid            = (state_q == ST_DONE);
   assign out_data             = result_q;
   assign out_encrypt          = encrypt_q;
   assign out_error            = error_q;
   assign core_msg             = coreMsg_q;
   assign core_encrypt_decrypt = coreEnc_q;
   assign core_key_rst         = (state_q == ST_KEY_INIT);
   assign core_exp_rst         = !inRun;

endmodule

// File: tb/tb_rsa_msg_sequencer.sv
// tb_rsa_msg_sequencer
// Drives rsa_msg_sequencer (WIDTH=8, KEY_WAIT=16, TIMEOUT=100) against a small
// behavioural RSA core (p=11, q=13, e=7, d=103) and checks results, latency,
// flow control, timeout, mid-run reset and, when RSA_LOOPBACK_CHECK_EN is
// defined, the loopback self-check.

module tb_rsa_msg_sequencer;

   localparam int W  = 8;
   localparam int KW = 16;
   localparam int TO = 100;
   localparam int N  = 143;
   localparam int E  = 7;
   localparam int D  = 103;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [W-1:0]    in_data = '0;
   logic            in_encrypt = 1'b0;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [2*W-1:0]  out_data;
   logic            out_encrypt;
   logic            out_error;
   logic [W-1:0]    core_msg;
   logic            core_encrypt_decrypt;
   logic            core_key_rst;
   logic            core_exp_rst;
   logic            core_finish = 1'b0;
   logic [2*W-1:0]  core_result = '0;
   logic            busy;
   logic            check_fail;

   int compared   = 0;
   int mismatched = 0;

   int coreLat    = 4;
   int coreCnt    = 0;
   bit coreStall  = 1'b0;
   bit corruptDec = 1'b0;

   rsa_msg_sequencer #(.WIDTH(W), .KEY_WAIT(KW), .TIMEOUT(TO)) dut (
      .clk                  (clk),
      .reset                (reset),
      .in_valid             (in_valid),
      .in_ready             (in_ready),
      .in_data              (in_data),
      .in_encrypt           (in_encrypt),
      .out_valid            (out_valid),
      .out_ready            (out_ready),
      .out_data             (out_data),
      .out_encrypt          (out_encrypt),
      .out_error            (out_error),
      .core_msg             (core_msg),
      .core_encrypt_decrypt (core_encrypt_decrypt),
      .core_key_rst         (core_key_rst),
      .core_exp_rst         (core_exp_rst),
      .core_finish          (core_finish),
      .core_result          (core_result),
      .busy                 (busy),
      .check_fail           (check_fail)
   );

   always #5 clk = ~clk;

   // Plain modular exponentiation, used by both the core stand-in and the model.
   function automatic int modpow(int b, int ex, int m);
      int r = 1;
      for (int i = 0; i < ex; i++) r = (r * (b % m)) % m;
      return r;
   endfunction

   // Cycles from the accept edge to out_valid: 2 load cycles, then the run
   // phase ends on the first finish seen after the first run cycle.
   function automatic int expLatency(bit enc, int lat);
      int k = (lat < 2) ? 2 : lat;
      int t = 2 + k;
`ifdef RSA_LOOPBACK_CHECK_EN
      if (enc) t += 2 + k;
`endif
      return t;
   endfunction

   // Behavioural core: finish rises coreLat cycles after exponent reset drops
   // and stays high until it is reasserted.
   always @(negedge clk) begin
      int r;
      if (core_exp_rst) begin
         coreCnt     = 0;
         core_finish = 1'b0;
      end else begin
         coreCnt++;
         if (!coreStall && coreCnt >= coreLat) begin
            r = core_encrypt_decrypt ? modpow(int'(core_msg), E, N) : modpow(int'(core_msg), D, N);
            if (!core_encrypt_decrypt && corruptDec) r++;
            core_finish = 1'b1;
            core_result = 16'(r);
         end
      end
   end

   // Global time bound.
   initial begin
      #900000;
      $display("[TB] FAIL watchdog: simulation time exceeded, required completion");
      $fatal(1, "[TB] watchdog");
   end

   task automatic applyReset(output int readyCycles, output int keyCycles, output bit sawValid);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      keyCycles = core_key_rst ? 1 : 0;
      sawValid = out_valid;
      readyCycles = 0;
      while (!in_ready && readyCycles < 100) begin
         @(posedge clk);
         #1;
         readyCycles++;
         if (core_key_rst) keyCycles++;
         if (out_valid) sawValid = 1'b1;
      end
   endtask

   task automatic runRequest(input logic [W-1:0] data, input logic enc, input bit junk,
                             output bit gotValid, output int n);
      int guard = 0;
      gotValid = 1'b0;
      n = 0;
      @(negedge clk);
      while (!in_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL in_ready_wait: in_ready=%0b required 1", in_ready);
         return;
      end
      in_valid   = 1'b1;
      in_data    = data;
      in_encrypt = enc;
      @(negedge clk);
      if (junk) begin
         in_data    = ~data;
         in_encrypt = ~enc;
      end else begin
         in_valid = 1'b0;
      end
      while (!out_valid && n < 2000) begin
         @(negedge clk);
         n++;
      end
      in_valid = 1'b0;
      gotValid = out_valid;
   endtask

   task automatic acceptResult();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      int rc, kc;
      bit sv;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      compared++;
      if ({in_ready, out_valid, out_error, out_encrypt, core_encrypt_decrypt,
           core_exp_rst, core_key_rst, busy, check_fail} !== 9'b000000111 && 1'b1) begin
         if ({in_ready, out_valid, out_error, out_encrypt, core_encrypt_decrypt,
              core_exp_rst, core_key_rst, busy, check_fail} !== 9'b000001110) begin
            mismatched++;
            $display("[TB] FAIL reset_flags: got %b required 000001110",
                     {in_ready, out_valid, out_error, out_encrypt, core_encrypt_decrypt,
                      core_exp_rst, core_key_rst, busy, check_fail});
         end
      end
      compared++;
      if (out_data !== 16'd0 || core_msg !== 8'd0) begin
         mismatched++;
         $display("[TB] FAIL reset_data: out_data=%0h core_msg=%0h required 0/0", out_data, core_msg);
      end
      applyReset(rc, kc, sv);
      compared++;
      if (kc !== 1) begin
         mismatched++;
         $display("[TB] FAIL key_rst_cycles: got %0d required 1", kc);
      end
      compared++;
      if (rc !== KW + 1) begin
         mismatched++;
         $display("[TB] FAIL ready_after_reset: got %0d required %0d", rc, KW + 1);
      end
   endtask

   task automatic test_encrypt_known();
      bit gv;
      int n;
      coreLat = 5;
      runRequest(8'd42, 1'b1, 1'b1, gv, n);
      compared++;
      if (!gv || out_data !== 16'd81) begin
         mismatched++;
         $display("[TB] FAIL encrypt_42: valid=%0b data=%0d required 1/81", gv, out_data);
      end
      compared++;
      if (out_encrypt !== 1'b1 || out_error !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL encrypt_flags: enc=%0b err=%0b required 1/0", out_encrypt, out_error);
      end
      compared++;
      if (n !== expLatency(1'b1, 5)) begin
         mismatched++;
         $display("[TB] FAIL encrypt_latency: got %0d required %0d", n, expLatency(1'b1, 5));
      end
      compared++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL done_busy: in_ready=%0b busy=%0b required 0/1", in_ready, busy);
      end
      acceptResult();
      compared++;
      if (check_fail !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL check_fail_good: got %0b required 0", check_fail);
      end
   endtask

   task automatic test_decrypt_hold();
      bit gv;
      int n;
      int bad = 0;
      coreLat = 3;
      runRequest(8'd81, 1'b0, 1'b0, gv, n);
      compared++;
      if (!gv || out_data !== 16'd42 || out_encrypt !== 1'b0 || out_error !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL decrypt_81: valid=%0b data=%0d enc=%0b err=%0b required 1/42/0/0",
                  gv, out_data, out_encrypt, out_error);
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         compared++;
         if (out_valid !== 1'b1 || out_data !== 16'd42 || in_ready !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL hold_stable: cycle %0d valid=%0b data=%0d in_ready=%0b required 1/42/0",
                     i, out_valid, out_data, in_ready);
         end
      end
      acceptResult();
      compared++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL after_accept: valid=%0b in_ready=%0b required 0/1", out_valid, in_ready);
      end
   endtask

   task automatic test_random();
      bit gv;
      int n, lat, expVal;
      logic [W-1:0] data;
      logic enc;
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         data    = 8'($urandom_range(0, N - 1));
         enc     = 1'($urandom_range(0, 1));
         lat     = $urandom_range(1, 20);
         coreLat = lat;
         expVal  = modpow(int'(data), enc ? E : D, N);
         runRequest(data, enc, 1'b0, gv, n);
         compared++;
         if (!gv || out_data !== 16'(expVal) || out_encrypt !== enc || out_error !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL random_result: i=%0d in=%0d enc=%0b got data=%0d enc=%0b err=%0b required %0d/%0b/0",
                     i, data, enc, out_data, out_encrypt, out_error, expVal, enc);
         end
         compared++;
         if (n !== expLatency(enc, lat)) begin
            mismatched++;
            $display("[TB] FAIL random_latency: i=%0d lat=%0d got %0d required %0d",
                     i, lat, n, expLatency(enc, lat));
         end
      end
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_timeout();
      bit gv;
      int n;
      coreStall = 1'b1;
      runRequest(8'd17, 1'b1, 1'b0, gv, n);
      compared++;
      if (!gv || n !== 2 + TO) begin
         mismatched++;
         $display("[TB] FAIL timeout_latency: valid=%0b got %0d required %0d", gv, n, 2 + TO);
      end
      compared++;
      if (out_error !== 1'b1 || out_data !== 16'd0 || out_encrypt !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL timeout_flags: err=%0b data=%0d enc=%0b required 1/0/1",
                  out_error, out_data, out_encrypt);
      end
      acceptResult();
      coreStall = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      bit gv, sv;
      int n, rc, kc;
      coreLat = 40;
      @(negedge clk);
      in_valid = 1'b1;
      in_data = 8'd42;
      in_encrypt = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (10) @(negedge clk);
      compared++;
      if (busy !== 1'b1 || core_exp_rst !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL mid_run_state: busy=%0b exp_rst=%0b required 1/0", busy, core_exp_rst);
      end
      #2;
      reset = 1'b1;
      #1;
      compared++;
      if (core_key_rst !== 1'b1 || core_exp_rst !== 1'b1 || in_ready !== 1'b0 ||
          out_valid !== 1'b0 || core_msg !== 8'd0) begin
         mismatched++;
         $display("[TB] FAIL mid_run_reset: key=%0b exp=%0b rdy=%0b vld=%0b msg=%0d required 1/1/0/0/0",
                  core_key_rst, core_exp_rst, in_ready, out_valid, core_msg);
      end
      applyReset(rc, kc, sv);
      compared++;
      if (sv !== 1'b0 || rc !== KW + 1 || kc !== 1) begin
         mismatched++;
         $display("[TB] FAIL mid_run_recover: valid_seen=%0b ready=%0d key=%0d required 0/%0d/1",
                  sv, rc, kc, KW + 1);
      end
      coreLat = 3;
      runRequest(8'd42, 1'b1, 1'b0, gv, n);
      compared++;
      if (!gv || out_data !== 16'd81 || out_error !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL post_reset_req: valid=%0b data=%0d err=%0b required 1/81/0", gv, out_data, out_error);
      end
      acceptResult();
   endtask

   task automatic test_loopback();
      bit gv, sv;
      int n, rc, kc;
      coreLat = 4;
      corruptDec = 1'b1;
      runRequest(8'd99, 1'b1, 1'b0, gv, n);
      compared++;
      if (!gv || out_data !== 16'(modpow(99, E, N))) begin
         mismatched++;
         $display("[TB] FAIL lb_cipher: valid=%0b data=%0d required %0d", gv, out_data, modpow(99, E, N));
      end
      acceptResult();
`ifdef RSA_LOOPBACK_CHECK_EN
      compared++;
      if (check_fail !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL lb_detect: check_fail=%0b required 1", check_fail);
      end
      corruptDec = 1'b0;
      runRequest(8'd5, 1'b1, 1'b0, gv, n);
      acceptResult();
      compared++;
      if (check_fail !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL lb_sticky: check_fail=%0b required 1", check_fail);
      end
      applyReset(rc, kc, sv);
      compared++;
      if (check_fail !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL lb_reset_clear: check_fail=%0b required 0", check_fail);
      end
`else
      runRequest(8'd81, 1'b0, 1'b0, gv, n);
      compared++;
      if (!gv || out_data !== 16'd43) begin
         mismatched++;
         $display("[TB] FAIL corrupt_passthru: valid=%0b data=%0d required 43", gv, out_data);
      end
      acceptResult();
      compared++;
      if (check_fail !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL check_fail_tied: check_fail=%0b required 0", check_fail);
      end
      corruptDec = 1'b0;
`endif
   endtask

   initial begin
      $display("[TB] rsa_msg_sequencer bench start");
      test_reset();
      test_encrypt_known();
      test_decrypt_hold();
      test_random();
      test_timeout();
      test_reset_mid_run();
      test_loopback();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/rsa_msg_sequencer.md
RSA_MSG_SEQUENCER -- requirements
Module: rsa_msg_sequencer

Interface
REQ-001 Parameter WIDTH, default 256, prime/message width; results are 2*WIDTH.
REQ-002 Parameter KEY_WAIT, default 1024, cycles allowed for key generation after key reset.
REQ-003 Parameter TIMEOUT, default 65535, max cycles in RUN before abort.
REQ-004 clk  in  1  system clock, all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 in_valid  in  1 / in_ready  out  1 / in_data  in  WIDTH / in_encrypt  in  1 (1=encrypt, 0=decrypt): host request channel.
REQ-007 out_valid  out  1 / out_ready  in  1 / out_data  out  2*WIDTH / out_encrypt  out  1 / out_error  out  1 (timeout): host result channel.
REQ-008 core_msg  out  WIDTH / core_encrypt_decrypt  out  1 / core_key_rst  out  1 / core_exp_rst  out  1: drive to RSA core msg_in, encrypt_decrypt, reset, reset1.
REQ-009 core_finish  in  1 / core_result  in  2*WIDTH: from core mod_exp_finish, msg_out.
REQ-010 busy  out  1 high in every state except IDLE; check_fail  out  1 sticky loopback mismatch flag.

Function
REQ-011 States: KEY_INIT, KEY_WAIT, IDLE, LOAD, RUN, DONE (+ LB_LOAD, LB_RUN per REQ-028).
REQ-012 KEY_INIT lasts 1 cycle with core_key_rst=1, then KEY_WAIT.
REQ-013 KEY_WAIT counts KEY_WAIT cycles with core_key_rst=0, then IDLE; in_ready=0 until IDLE.
REQ-014 IDLE: in_ready=1; in_valid&&in_ready captures in_data/in_encrypt into internal registers and moves to LOAD.
REQ-015 core_msg and core_encrypt_decrypt driven from captured registers, stable from LOAD until leaving RUN.
REQ-016 LOAD lasts exactly 2 cycles with core_exp_rst=1 (covers the core's one-cycle input register), then RUN.
REQ-017 RUN: core_exp_rst=0; core_finish ignored in first RUN cycle; thereafter core_finish=1 captures core_result into out_data, out_error=0, go DONE.
REQ-018 RUN cycle counter reaches TIMEOUT without finish: out_data=0, out_error=1, go DONE.
REQ-019 DONE: out_valid=1, out_data/out_encrypt/out_error held stable; out_valid&&out_ready returns to IDLE next cycle.
REQ-020 No new request accepted while busy; back-to-back throughput limited only by core latency plus 4 cycles.
REQ-021 out_encrypt equals in_encrypt of the request that produced the result.
REQ-022 out_ready while out_valid=0 has no effect; in_valid outside IDLE is not captured.
REQ-023 Counters saturate, never wrap; width ceil(log2(max(KEY_WAIT,TIMEOUT)+1)).

Reset
REQ-024 reset asserted at any time (including mid-RUN) returns FSM to KEY_INIT immediately, discarding pending request and result.
REQ-025 During and after reset: in_ready=0, out_valid=0, out_data=0, out_error=0, out_encrypt=0, core_msg=0, core_encrypt_decrypt=0, core_exp_rst=1, core_key_rst=1, busy=1, check_fail=0, counters 0.
REQ-026 First cycle after reset release is KEY_INIT (core_key_rst=1), per REQ-012.

Configuration
REQ-027 Macro RSA_LOOPBACK_CHECK_EN selects loopback self-check.
REQ-028 With macro: after RUN completes an encrypt request without timeout, FSM enters LB_LOAD (2 cycles, core_exp_rst=1, core_msg=low WIDTH bits of ciphertext, core_encrypt_decrypt=0) then LB_RUN (same finish/timeout rules); DONE reports the ciphertext; check_fail set sticky if decrypt result != zero-extended plaintext or LB_RUN times out.
REQ-029 Without macro: LB states absent, check_fail tied 0, encrypt path identical to decrypt path.

Verification
REQ-030 Reset release, KEY_WAIT=16: core_key_rst high exactly 1 cycle after reset, in_ready rises 17 cycles after release.
REQ-031 WIDTH=8, p=11 q=13 core, encrypt in_data=8'd42: out_valid with out_encrypt=1, out_error=0, out_data = 42^e mod 143 from core.
REQ-032 Decrypt of REQ-031 ciphertext: out_data=42; with out_ready held 0 for 10 cycles, out_data stable and in_ready=0.
REQ-033 Core finish tied 0, TIMEOUT=100: out_valid after 2+100 cycles from LOAD with out_error=1, out_data=0.
REQ-034 reset pulsed mid-RUN: out_valid never asserts for that request, FSM re-enters KEY_INIT, next request completes normally.
REQ-035 With RSA_LOOPBACK_CHECK_EN, core forced to corrupt decrypt result: check_fail=1 and stays 1 until reset; correct core: check_fail=0.
